// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung prefix adders: FSM states, log2 helper
// and the up/down-sweep index predicates that define the prefix tree.
package bk_pkg;

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} bk_state_t;

  function automatic int bk_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Up-sweep: bit j combines with j-2^lvl when j closes a block of 2^(lvl+1).
  function automatic logic bk_up_sel(input int j, input int lvl);
    return ((j + 1) % (1 << (lvl + 1))) == 0;
  endfunction

  // Down-sweep: fills the mid-block bits; j == 2^lvl-1 is already complete.
  function automatic logic bk_dn_sel(input int j, input int lvl);
    return (((j + 1) % (1 << (lvl + 1))) == (1 << lvl)) && (j > (1 << lvl));
  endfunction

endpackage

// File: rtl/carry_op.sv
// Brent-Kung prefix operator: (G,P)hi o (G,P)lo.
module carry_op (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;

endmodule

// File: rtl/bk_iter_adder_ctrl.sv
// Iterative Brent-Kung adder: one rank of carry_op cells walks the up- and
// down-sweep trees level by level, with valid/ready on both sides.
module bk_iter_adder_ctrl
  import bk_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int L  = bk_log2(N);
  localparam int LW = (L > 1) ? $clog2(L) : 1;

  bk_state_t      state_q, state_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic [N-1:0]   g_q, g_d, p_q, p_d, po_q, po_d;
  logic           cin_q, cin_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ov_q, ov_d;
  logic           ir_q, ir_d;

  logic [N-1:1]   sel, gl, pl, gc, pc;
  logic [N-1:0]   g_nx, p_nx;
  logic           accept;

  // Per-bit operand muxes: the low input and the enable depend on state/lvl.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    gl  = '0;
    pl  = '0;
    for (int j = 1; j < N; j++) begin
      for (int l = 0; l < L; l++) begin
        if (lvl_q == LW'(l)) begin
          if (state_q == UP   && bk_up_sel(j, l)) sel[j] = 1'b1;
          if (state_q == DOWN && bk_dn_sel(j, l)) sel[j] = 1'b1;
          if (j >= (1 << l)) begin
            gl[j] = g_q[j - (1 << l)];
            pl[j] = p_q[j - (1 << l)];
          end
        end
      end
    end
  end

  for (genvar j = 1; j < N; j++) begin : g_rank
    carry_op u_op (
      .gh_i (g_q[j]),
      .ph_i (p_q[j]),
      .gl_i (gl[j]),
      .pl_i (pl[j]),
      .g_o  (gc[j]),
      .p_o  (pc[j])
    );
  end

  always_comb begin
    g_nx[0] = g_q[0];
    p_nx[0] = p_q[0];
    for (int j = 1; j < N; j++) begin
      g_nx[j] = sel[j] ? gc[j] : g_q[j];
      p_nx[j] = sel[j] ? pc[j] : p_q[j];
    end
  end

  assign accept = in_valid && ir_q;

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    g_d     = g_q;
    p_d     = p_q;
    po_d    = po_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          po_d    = a ^ b;
          p_d     = a ^ b;
          g_d     = a & b;
          g_d[0]  = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
          cin_d   = cin;
          lvl_d   = '0;
          state_d = UP;
        end
      end
      UP: begin
        g_d = g_nx;
        p_d = p_nx;
        if (lvl_q == LW'(L - 1)) begin
          lvl_d   = LW'(L - 2);
          state_d = DOWN;
        end else begin
          lvl_d = lvl_q + LW'(1);
        end
      end
      DOWN: begin
        g_d = g_nx;
        p_d = p_nx;
        if (lvl_q == '0) begin
          sum_d   = po_q ^ {g_nx[N-2:0], cin_q};
          cout_d  = g_nx[N-1];
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          lvl_d = lvl_q - LW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready tracks the next state so it is low while reset is held.
  assign ir_d = (state_d == IDLE);

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the G/P working registers are reset too, so no stale tree survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      g_q     <= '0;
      p_q     <= '0;
      po_q    <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      g_q     <= g_d;
      p_q     <= p_d;
      po_q    <= po_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      ir_q    <= ir_d;
    end
  end

  assign in_ready  = ir_q;
  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bk_iter_adder_ctrl.sv
// Self-checking bench for bk_iter_adder_ctrl at N=4, 8 and 32: directed table,
// backpressure and mid-operation reset sequences, then randomized traffic.
module tb_bk_iter_adder_ctrl;

  localparam int WID [3] = '{4, 8, 32};
  localparam int LAT [3] = '{4, 6, 10};

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [2:0]  out_ready;
  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  cout_w;
  logic [31:0] a_v, b_v;
  logic        cin_v;
  logic [3:0]  sum4;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic [31:0] sum_w [3];

  int n_vec = 0;
  int n_err = 0;

  assign sum_w[0] = {28'd0, sum4};
  assign sum_w[1] = {24'd0, sum8};
  assign sum_w[2] = sum32;

  bk_iter_adder_ctrl #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a_v[3:0]), .b(b_v[3:0]), .cin(cin_v), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .sum(sum4), .cout(cout_w[0])
  );

  bk_iter_adder_ctrl #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a_v[7:0]), .b(b_v[7:0]), .cin(cin_v), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .sum(sum8), .cout(cout_w[1])
  );

  bk_iter_adder_ctrl #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a_v), .b(b_v), .cin(cin_v), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .sum(sum32), .cout(cout_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition truncated to w bits; carry is bit w.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [32:0] m, full;
    m    = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c};
    return {full[w], full[31:0] & m[31:0]};
  endfunction

  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // One transaction: accept, measure latency, check result, hold, release.
  task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic [31:0] es, input logic ec,
                       input int gap, input int hold);
    bit ok;
    int cyc;
    repeat (gap) @(negedge clk);
    wait_ready(d, ok);
    if (!ok) return;
    a_v = a; b_v = b; cin_v = c;
    in_valid[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    a_v = $urandom; b_v = $urandom; cin_v = 1'($urandom_range(0, 1));
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid_w[d]) begin
        cyc = i;
        break;
      end
      check("in_ready_busy", {63'd0, in_ready_w[d]}, 64'd0);
    end
    check("latency", 64'(cyc), 64'(LAT[d]));
    if (cyc == 0) return;
    check("sum", {32'd0, sum_w[d]}, {32'd0, es});
    check("cout", {63'd0, cout_w[d]}, {63'd0, ec});
    check("in_ready_done", {63'd0, in_ready_w[d]}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid_w[d]}, 64'd1);
      check("hold_sum", {32'd0, sum_w[d]}, {32'd0, es});
      check("hold_cout", {63'd0, cout_w[d]}, {63'd0, ec});
      check("hold_in_ready", {63'd0, in_ready_w[d]}, 64'd0);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("release_valid", {63'd0, out_valid_w[d]}, 64'd0);
    check("release_in_ready", {63'd0, in_ready_w[d]}, 64'd1);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] s;
    logic        co;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic        rc;
    bit          ok;

    tbl[0] = '{1, 32'hFF,       32'h01,       1'b0, 32'h00,       1'b1};
    tbl[1] = '{1, 32'h5A,       32'h3C,       1'b1, 32'h97,       1'b0};
    tbl[2] = '{1, 32'h80,       32'h80,       1'b1, 32'h01,       1'b1};
    tbl[3] = '{0, 32'hF,        32'hF,        1'b1, 32'hF,        1'b1};
    tbl[4] = '{0, 32'h7,        32'h8,        1'b1, 32'h0,        1'b1};
    tbl[5] = '{0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    tbl[6] = '{2, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[7] = '{2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};

    in_valid  = '0;
    out_ready = '0;
    a_v = '0; b_v = '0; cin_v = 1'b0;
    rst_n = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) begin
      check("reset_in_ready", {63'd0, in_ready_w[d]}, 64'd0);
      check("reset_out_valid", {63'd0, out_valid_w[d]}, 64'd0);
      check("reset_sum", {32'd0, sum_w[d]}, 64'd0);
      check("reset_cout", {63'd0, cout_w[d]}, 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co, 0, 0);
    end

    // Backpressure for 10 cycles, then an immediate follow-on transaction.
    do_op(1, 32'hA5, 32'h3C, 1'b1, 32'hE2, 1'b0, 0, 10);
    do_op(1, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 0, 0);

    // Reset during UP: outputs drop at once and no stale result appears.
    wait_ready(1, ok);
    a_v = 32'hC3; b_v = 32'h7E; cin_v = 1'b1;
    in_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready_w[1]}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid_w[1]}, 64'd0);
    check("midrst_sum", {32'd0, sum_w[1]}, 64'd0);
    check("midrst_cout", {63'd0, cout_w[1]}, 64'd0);
    repeat (2) @(negedge clk);
    check("midrst_held_valid", {63'd0, out_valid_w[1]}, 64'd0);
    rst_n = 1'b1;
    do_op(1, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 0, 0);

    for (int d = 1; d < 3; d++) begin
      for (int k = 0; k < 1200; k++) begin
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        r  = ref_add(WID[d], ra, rb, rc);
        do_op(d, ra, rb, rc, r[31:0], r[32], $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
